sc_regbank_reader: RTL
======================

# sc_regbank_reader

Read-side companion to the general-purpose register bank in the uDataPath. Selects one of NUM_REGS register outputs and captures it into a registered output bus through a request/valid handshake. A scan mode streams every register out in index order. It feeds the debug/display path and the ALU operand bus without disturbing the registers themselves.

## Interface
Parameters:
- DATAWIDTH_BUS, 32, width of each register and of the output bus
- NUM_REGS, 8, number of registers in the bank (2..2^SEL_WIDTH)
- SEL_WIDTH, 3, width of the register index

Ports:
- SC_RegBANKREAD_CLOCK_50  in  1  system clock; all state updates on the falling edge
- SC_RegGENERAL_Reset_InHigh  in  1  reset, asynchronous, active-high
- SC_RegBANKREAD_RegBank_In  in  NUM_REGS*DATAWIDTH_BUS  flattened register outputs; register i occupies [i*DATAWIDTH_BUS +: DATAWIDTH_BUS]
- SC_RegBANKREAD_ReadReq_InHigh  in  1  single-read request
- SC_RegBANKREAD_ReadSel_In  in  SEL_WIDTH  index for a single read
- SC_RegBANKREAD_ScanStart_InHigh  in  1  start a full-bank scan
- SC_RegBANKREAD_DataBUS_Out  out  DATAWIDTH_BUS  captured register value
- SC_RegBANKREAD_Sel_Out  out  SEL_WIDTH  index of the value on DataBUS_Out
- SC_RegBANKREAD_Valid_OutHigh  out  1  DataBUS_Out/Sel_Out valid this cycle (1-cycle pulse per word)
- SC_RegBANKREAD_Busy_OutHigh  out  1  block is not IDLE
- SC_RegBANKREAD_Error_OutHigh  out  1  last single read used an out-of-range index (sticky until the next accepted request)
- SC_RegBANKREAD_ScanDone_OutHigh  out  1  1-cycle pulse with the last scan word
- SC_RegBANKREAD_Parity_Out  out  1  even parity of DataBUS_Out (see Configuration)

## Operation
- FSM states: IDLE, ADDR, CAPTURE, SCAN.
- IDLE: ReadReq high at an edge -> latch ReadSel into the index register, clear Error, go to ADDR. Otherwise ScanStart high -> index = 0, go to SCAN. ReadReq has priority when both are high.
- ADDR: settling cycle for the index mux; go to CAPTURE.
- CAPTURE: if index < NUM_REGS, DataBUS_Out <= register[index]; otherwise DataBUS_Out <= 0 and Error <= 1. Sel_Out <= index, Valid pulses, return to IDLE.
- SCAN: each edge, DataBUS_Out <= register[index], Sel_Out <= index, Valid high, index increments. When index = NUM_REGS-1, ScanDone pulses with that word and the FSM returns to IDLE. Index does not wrap past NUM_REGS-1.
- Requests and ScanStart arriving while Busy are ignored and not queued.
- DataBUS_Out and Sel_Out hold their last captured value while Valid is low.
- Reset values: DataBUS_Out 0, Sel_Out 0, Valid 0, Busy 0, Error 0, ScanDone 0, Parity 0, state IDLE.

## Timing
- Single read: request sampled at edge N; Valid and data are present after edge N+2. Busy is high after edges N and N+1.
- Scan: ScanStart sampled at edge N; words 0..NUM_REGS-1 appear after edges N+1..N+NUM_REGS with Valid continuously high. ScanDone coincides with the last word.
- The captured value is the register content at the capture edge, not at the request edge.
- Reset asserted mid-read or mid-scan: all outputs take their reset values immediately. No Valid is issued for the aborted word. The block is in IDLE after reset is released.
- Back-to-back single reads: the earliest next acceptance is the edge after Valid, giving 3 cycles per read.

## Configuration
- SC_REGBANKREAD_PARITY_EN defined: Parity_Out is registered alongside DataBUS_Out and equals the XOR of all its bits. Parity resets to 0 and is 0 on an out-of-range read.
- Undefined: Parity_Out is tied to 0 and the parity logic is absent.

## Structure
- Package sc_regbank_reader_pkg holds the FSM state encoding (IDLE, ADDR, CAPTURE, SCAN) and the localparam for the flattened-bus slice width.
- Sub-module sc_regbank_reader_mux is a combinational indexed select of one DATAWIDTH_BUS slice from the flattened bus, with an in-range flag output. The top level contains the FSM, the index counter and the output registers.

## Test plan
- Reset, then ReadReq with ReadSel=5 and reg5=32'hDEADBEEF -> after 2 edges DataBUS_Out=32'hDEADBEEF, Sel_Out=5, Valid pulses for 1 cycle, Error=0.
- NUM_REGS=6, ReadSel=7 -> DataBUS_Out=0 and Error=1; Error clears on the next accepted ReadReq with ReadSel=2.
- ScanStart with reg i = i+32'h100 -> 8 consecutive Valid words 32'h100..32'h107, Sel_Out=0..7, ScanDone only with word 7, then Busy=0.
- ReadReq and ScanStart high together -> single read performed, no scan. ReadReq pulsed during a scan -> ignored, and the scan sequence is unchanged.
- Reset asserted after the 3rd scan word -> all outputs 0 immediately. The next ScanStart restarts from Sel_Out=0.
- With SC_REGBANKREAD_PARITY_EN, reading 32'h00000007 -> Parity_Out=1. Without the macro, Parity_Out stays 0.

Source files
------------

// File: rtl/sc_regbank_reader_pkg.sv
// Shared definitions for the register-bank reader: FSM encoding and default bus slice width.
package sc_regbank_reader_pkg;

  localparam int unsigned BusSliceWidth = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAddr    = 2'd1,
    StCapture = 2'd2,
    StScan    = 2'd3
  } readerState_t;

endpackage

// File: rtl/sc_regbank_reader_mux.sv
// Combinational indexed select of one register slice from the flattened bank bus,
// with a flag telling whether the index names an existing register.
module sc_regbank_reader_mux
  import sc_regbank_reader_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = BusSliceWidth,
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned SEL_WIDTH     = 3
) (
  input  logic [NUM_REGS*DATAWIDTH_BUS-1:0] SC_RegBANKMUX_RegBank_In,
  input  logic [SEL_WIDTH-1:0]              SC_RegBANKMUX_Sel_In,
  output logic [DATAWIDTH_BUS-1:0]          SC_RegBANKMUX_Data_Out,
  output logic                              SC_RegBANKMUX_InRange_OutHigh
);

  // Out-of-range indices fall through to zero data and a low in-range flag.
  always_comb begin
    SC_RegBANKMUX_Data_Out        = '0;
    SC_RegBANKMUX_InRange_OutHigh = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (SC_RegBANKMUX_Sel_In == SEL_WIDTH'(i)) begin
        SC_RegBANKMUX_Data_Out        = SC_RegBANKMUX_RegBank_In[i*DATAWIDTH_BUS +: DATAWIDTH_BUS];
        SC_RegBANKMUX_InRange_OutHigh = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_regbank_reader.sv
// Register-bank reader: single indexed reads and full-bank scans through a valid handshake.
// Optional SC_REGBANKREAD_PARITY_EN adds a registered even-parity bit of the output bus.
module sc_regbank_reader
  import sc_regbank_reader_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS = BusSliceWidth,
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned SEL_WIDTH     = 3
) (
  input  logic                              SC_RegBANKREAD_CLOCK_50,
  input  logic                              SC_RegGENERAL_Reset_InHigh,
  input  logic [NUM_REGS*DATAWIDTH_BUS-1:0] SC_RegBANKREAD_RegBank_In,
  input  logic                              SC_RegBANKREAD_ReadReq_InHigh,
  input  logic [SEL_WIDTH-1:0]              SC_RegBANKREAD_ReadSel_In,
  input  logic                              SC_RegBANKREAD_ScanStart_InHigh,
  output logic [DATAWIDTH_BUS-1:0]          SC_RegBANKREAD_DataBUS_Out,
  output logic [SEL_WIDTH-1:0]              SC_RegBANKREAD_Sel_Out,
  output logic                              SC_RegBANKREAD_Valid_OutHigh,
  output logic                              SC_RegBANKREAD_Busy_OutHigh,
  output logic                              SC_RegBANKREAD_Error_OutHigh,
  output logic                              SC_RegBANKREAD_ScanDone_OutHigh,
  output logic                              SC_RegBANKREAD_Parity_Out
);

  localparam logic [SEL_WIDTH-1:0] LastIndex = SEL_WIDTH'(NUM_REGS - 1);

  readerState_t               stateQ;
  logic [SEL_WIDTH-1:0]       indexQ;
  logic [DATAWIDTH_BUS-1:0]   muxData;
  logic                       muxInRange;

  sc_regbank_reader_mux #(
    .DATAWIDTH_BUS (DATAWIDTH_BUS),
    .NUM_REGS      (NUM_REGS),
    .SEL_WIDTH     (SEL_WIDTH)
  ) u_mux (
    .SC_RegBANKMUX_RegBank_In      (SC_RegBANKREAD_RegBank_In),
    .SC_RegBANKMUX_Sel_In          (indexQ),
    .SC_RegBANKMUX_Data_Out        (muxData),
    .SC_RegBANKMUX_InRange_OutHigh (muxInRange)
  );

  always_ff @(negedge SC_RegBANKREAD_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      stateQ                          <= StIdle;
      indexQ                          <= '0;
      SC_RegBANKREAD_DataBUS_Out      <= '0;
      SC_RegBANKREAD_Sel_Out          <= '0;
      SC_RegBANKREAD_Valid_OutHigh    <= 1'b0;
      SC_RegBANKREAD_Busy_OutHigh     <= 1'b0;
      SC_RegBANKREAD_Error_OutHigh    <= 1'b0;
      SC_RegBANKREAD_ScanDone_OutHigh <= 1'b0;
    end else begin
      SC_RegBANKREAD_Valid_OutHigh    <= 1'b0;
      SC_RegBANKREAD_ScanDone_OutHigh <= 1'b0;
      case (stateQ)
        StIdle: begin
          // A single read wins over a scan when both are requested together.
          if (SC_RegBANKREAD_ReadReq_InHigh) begin
            indexQ                       <= SC_RegBANKREAD_ReadSel_In;
            SC_RegBANKREAD_Error_OutHigh <= 1'b0;
            SC_RegBANKREAD_Busy_OutHigh  <= 1'b1;
            stateQ                       <= StAddr;
          end else if (SC_RegBANKREAD_ScanStart_InHigh) begin
            indexQ                      <= '0;
            SC_RegBANKREAD_Busy_OutHigh <= 1'b1;
            stateQ                      <= StScan;
          end
        end
        StAddr: begin
          stateQ <= StCapture;
        end
        StCapture: begin
          SC_RegBANKREAD_DataBUS_Out   <= muxData;
          SC_RegBANKREAD_Sel_Out       <= indexQ;
          SC_RegBANKREAD_Valid_OutHigh <= 1'b1;
          SC_RegBANKREAD_Busy_OutHigh  <= 1'b0;
          if (!muxInRange) begin
            SC_RegBANKREAD_Error_OutHigh <= 1'b1;
          end
          stateQ <= StIdle;
        end
        StScan: begin
          SC_RegBANKREAD_DataBUS_Out   <= muxData;
          SC_RegBANKREAD_Sel_Out       <= indexQ;
          SC_RegBANKREAD_Valid_OutHigh <= 1'b1;
          if (indexQ == LastIndex) begin
            SC_RegBANKREAD_ScanDone_OutHigh <= 1'b1;
            SC_RegBANKREAD_Busy_OutHigh     <= 1'b0;
            stateQ                          <= StIdle;
          end else begin
            indexQ <= indexQ + SEL_WIDTH'(1);
          end
        end
        default: begin
          SC_RegBANKREAD_Busy_OutHigh <= 1'b0;
          stateQ                      <= StIdle;
        end
      endcase
    end
  end

`ifdef SC_REGBANKREAD_PARITY_EN
  logic parityQ;

  // Loaded on the same edges as the data bus; out-of-range data is zero, so parity is zero too.
  always_ff @(negedge SC_RegBANKREAD_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      parityQ <= 1'b0;
    end else if (stateQ == StCapture || stateQ == StScan) begin
      parityQ <= ^muxData;
    end
  end

  assign SC_RegBANKREAD_Parity_Out = parityQ;
`else
  assign SC_RegBANKREAD_Parity_Out = 1'b0;
`endif

endmodule
